// File: rtl/weakcore_lsu_if.sv
// weakcore_lsu_if: request/response and memory-bus signal bundle for the
// weakcore load/store unit.
//
//   req_*   : execute-stage request (valid/ready handshake)
//   resp_*  : one-cycle completion pulse with load data / error
//   bus_*   : single-beat memory bus (req/ack handshake, byte-lane mask)
//
// Modports:
//   slave  : the load/store unit itself
//   master : the environment around it (execute stage + memory bus model)
interface weakcore_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic                req_valid;
  logic                req_ready;
  logic                req_wr;
  logic [1:0]          req_size;
  logic                req_signed;
  logic [ADDR_W-1:0]   req_addr;
  logic [XLEN-1:0]     req_wdata;

  logic                resp_valid;
  logic [XLEN-1:0]     resp_rdata;
  logic                resp_err;

  logic                bus_req;
  logic                bus_ack;
  logic                bus_wr;
  logic [ADDR_W-1:0]   bus_addr;
  logic [XLEN-1:0]     bus_out;
  logic [XLEN-1:0]     bus_in;
  logic [XLEN/8-1:0]   bus_wr_mask;

  modport slave (
    input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output bus_req, bus_wr, bus_addr, bus_out, bus_wr_mask,
    input  bus_ack, bus_in
  );

  modport master (
    output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  bus_req, bus_wr, bus_addr, bus_out, bus_wr_mask,
    output bus_ack, bus_in
  );
endinterface

// File: rtl/weakcore_lsu.sv
// weakcore_lsu: load/store unit between the execute stage and the shared
// memory bus. Takes one byte/half/word/(dword) access at a time, any
// alignment, and performs it as one or two aligned bus beats. Accesses that
// straddle a bus-word boundary are split into a low beat and a high beat.
// Loads return sign- or zero-extended data; stores return a completion pulse.
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   lsu : weakcore_lsu_if.slave bundle
//         req_valid/req_ready/req_wr/req_size/req_signed/req_addr/req_wdata
//         resp_valid/resp_rdata/resp_err
//         bus_req/bus_ack/bus_wr/bus_addr/bus_out/bus_in/bus_wr_mask
//
// Every output is either a state decode or a register gated by a state
// decode, so nothing on req_* or bus_in reaches an output combinationally.
module weakcore_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  weakcore_lsu_if.slave lsu
);

  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int MW    = 2 * BYTES;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT0 = 2'd1;
  localparam logic [1:0] S_BEAT1 = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        r_state;
  logic              r_wr;
  logic              r_signed;
  logic              r_err;
  logic              r_split;
  logic [1:0]        r_size;
  logic [OFFW-1:0]   r_off;
  logic [ADDR_W-1:0] r_addr0;
  logic [MW-1:0]     r_mask;
  logic [2*XLEN-1:0] r_wd;
  logic [XLEN-1:0]   r_beat0;
  logic [XLEN-1:0]   r_rdata;

  logic              w_accept;
  logic              w_legal;
  logic              w_in_beat;
  logic              w_ack;
  logic [OFFW-1:0]   w_off;
  logic [3:0]        w_nbytes;
  logic [MW-1:0]     w_mask;
  logic [2*XLEN-1:0] w_wd;
  logic [2*XLEN-1:0] w_wd_m;

  // Pick the addressed bytes out of the (beat1:beat0) pair, keep the access
  // width, and extend from its MSB when signed.
  function automatic logic [XLEN-1:0] ld_extend(
    input logic [2*XLEN-1:0] pair,
    input logic [OFFW-1:0]   off,
    input logic [1:0]        size,
    input logic              sgn
  );
    logic [XLEN-1:0] v;
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] top;
    int              nbits;
    v     = XLEN'(pair >> {off, 3'b000});
    nbits = 8 << size;
    keep  = '1;
    if (nbits < XLEN) keep = (XLEN'(1) << nbits) - XLEN'(1);
    else              nbits = XLEN;
    top       = v >> (nbits - 1);
    ld_extend = v & keep;
    if (sgn && top[0]) ld_extend = ld_extend | ~keep;
  endfunction

  assign w_accept  = lsu.req_valid && (r_state == S_IDLE);
  assign w_legal   = (lsu.req_size != 2'd3) || (XLEN == 64);
  assign w_in_beat = (r_state == S_BEAT0) || (r_state == S_BEAT1);
  assign w_ack     = lsu.bus_ack && w_in_beat;
  assign w_off     = lsu.req_addr[OFFW-1:0];
  assign w_nbytes  = 4'd1 << lsu.req_size;
  assign w_mask    = MW'((16'd1 << w_nbytes) - 16'd1) << w_off;

  // Store data is shifted into lane position across a double-width window;
  // lanes outside the access (and every lane of a load) are forced to zero.
  always_comb begin
    w_wd   = {{XLEN{1'b0}}, lsu.req_wdata} << {w_off, 3'b000};
    w_wd_m = '0;
    for (int b = 0; b < MW; b++) begin
      if (lsu.req_wr && w_mask[b]) w_wd_m[8*b +: 8] = w_wd[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) r_state <= w_legal ? S_BEAT0 : S_RESP;
        S_BEAT0: if (w_ack)    r_state <= r_split ? S_BEAT1 : S_RESP;
        S_BEAT1: if (w_ack)    r_state <= S_RESP;
        default:               r_state <= S_IDLE;
      endcase
    end
  end

  // Request/beat data: only ever observed through state-gated outputs, so it
  // needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wr     <= lsu.req_wr;
      r_signed <= lsu.req_signed;
      r_size   <= lsu.req_size;
      r_off    <= w_off;
      r_err    <= !w_legal;
      r_addr0  <= lsu.req_addr & ~ADDR_W'(BYTES - 1);
      r_mask   <= w_mask;
      r_split  <= |w_mask[MW-1:BYTES];
      r_wd     <= w_wd_m;
      r_rdata  <= '0;
    end
    if (w_ack && r_state == S_BEAT0) begin
      r_beat0 <= lsu.bus_in;
      if (!r_split)
        r_rdata <= r_wr ? '0 : ld_extend({XLEN'(0), lsu.bus_in}, r_off, r_size, r_signed);
    end
    if (w_ack && r_state == S_BEAT1) begin
      r_rdata <= r_wr ? '0 : ld_extend({lsu.bus_in, r_beat0}, r_off, r_size, r_signed);
    end
  end

  assign lsu.req_ready   = (r_state == S_IDLE);
  assign lsu.bus_req     = w_in_beat;
  assign lsu.bus_wr      = w_in_beat && r_wr;
  assign lsu.bus_addr    = (r_state == S_BEAT0) ? r_addr0 :
                           (r_state == S_BEAT1) ? r_addr0 + ADDR_W'(BYTES) : '0;
  assign lsu.bus_wr_mask = (r_state == S_BEAT0) ? r_mask[BYTES-1:0] :
                           (r_state == S_BEAT1) ? r_mask[MW-1:BYTES] : '0;
  assign lsu.bus_out     = (r_state == S_BEAT0) ? r_wd[XLEN-1:0] :
                           (r_state == S_BEAT1) ? r_wd[2*XLEN-1:XLEN] : '0;
  assign lsu.resp_valid  = (r_state == S_RESP);
  assign lsu.resp_rdata  = (r_state == S_RESP) ? r_rdata : '0;
  assign lsu.resp_err    = (r_state == S_RESP) && r_err;

endmodule

// File: tb/tb_weakcore_lsu.sv
// tb_weakcore_lsu: scoreboard bench for weakcore_lsu (XLEN=32, ADDR_W=32).
// Expected bus beats and responses are queued as each request is issued; a
// per-cycle service routine plays the memory bus and compares beats and
// responses as the unit produces them.
module tb_weakcore_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  weakcore_lsu_if #(.XLEN(32), .ADDR_W(32)) u_if ();

  weakcore_lsu #(.XLEN(32), .ADDR_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .lsu (u_if.slave)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] dout;
    logic [31:0] rin;
    int          dly;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } resp_t;

  beat_t beat_q[$];
  resp_t resp_q[$];
  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int bwait = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One negedge worth of bus model and response monitor.
  task automatic service();
    beat_t b;
    resp_t e;
    if (rst) begin
      u_if.bus_ack = 1'b0;
      bwait = 0;
    end else begin
      if (u_if.resp_valid) begin
        if (resp_q.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          e = resp_q.pop_front();
          chk("resp_rdata", u_if.resp_rdata, e.rdata);
          chk("resp_err", u_if.resp_err, e.err);
          chk("resp_latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end else begin
        chk("idle_rdata", u_if.resp_rdata, 0);
        chk("idle_err", u_if.resp_err, 0);
      end

      u_if.bus_ack = 1'b0;
      if (u_if.bus_req) begin
        chk("ready_in_beat", u_if.req_ready, 0);
        if (beat_q.size() == 0) begin
          chk("bus_unexpected", 1, 0);
        end else begin
          b = beat_q[0];
          chk("bus_addr", u_if.bus_addr, b.addr);
          chk("bus_wr", u_if.bus_wr, b.wr);
          chk("bus_wr_mask", u_if.bus_wr_mask, b.mask);
          chk("bus_out", u_if.bus_out, b.dout);
          if (bwait == b.dly) begin
            u_if.bus_ack = 1'b1;
            u_if.bus_in  = b.rin;
            void'(beat_q.pop_front());
            bwait = 0;
          end else begin
            bwait++;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    service();
  endtask

  task automatic push_beat(input logic [31:0] addr, input logic wr, input logic [3:0] mask,
                           input logic [31:0] dout, input logic [31:0] rin, input int dly);
    beat_q.push_back('{addr: addr, wr: wr, mask: mask, dout: dout, rin: rin, dly: dly});
  endtask

  task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    int k;
    k = 0;
    while (!u_if.req_ready && k < 100) begin
      step();
      k++;
    end
    chk("req_ready_before_issue", u_if.req_ready, 1);
    u_if.req_valid  = 1'b1;
    u_if.req_wr     = wr;
    u_if.req_size   = size;
    u_if.req_signed = sgn;
    u_if.req_addr   = addr;
    u_if.req_wdata  = wdata;
    resp_q.push_back('{rdata: exp_rdata, err: exp_err, lat: lat, acc: cyc});
    step();
    u_if.req_valid  = 1'b0;
    u_if.req_wdata  = 32'hX5X5_X5X5;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((beat_q.size() != 0 || resp_q.size() != 0) && k < 300) begin
      step();
      k++;
    end
    chk("drain_pending", 64'(beat_q.size() + resp_q.size()), 0);
    repeat (3) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  k;
    logic seen;
    u_if.req_valid  = 1'b0;
    u_if.req_wr     = 1'b0;
    u_if.req_size   = 2'd0;
    u_if.req_signed = 1'b0;
    u_if.req_addr   = '0;
    u_if.req_wdata  = '0;
    u_if.bus_ack    = 1'b0;
    u_if.bus_in     = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready", u_if.req_ready, 1);
    chk("rst_bus_req", u_if.bus_req, 0);
    chk("rst_bus_wr", u_if.bus_wr, 0);
    chk("rst_resp_valid", u_if.resp_valid, 0);
    chk("rst_resp_err", u_if.resp_err, 0);
    chk("rst_bus_addr", u_if.bus_addr, 0);
    chk("rst_bus_out", u_if.bus_out, 0);
    chk("rst_bus_wr_mask", u_if.bus_wr_mask, 0);
    chk("rst_resp_rdata", u_if.resp_rdata, 0);
    rst = 1'b0;
    step();

    // Aligned word load
    push_beat(32'h100, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    drain();

    // Split half load, signed then unsigned back-to-back
    push_beat(32'h100, 1'b0, 4'b1000, 32'h0, 32'hAB000000, 0);
    push_beat(32'h104, 1'b0, 4'b0001, 32'h0, 32'h000000CD, 0);
    issue(1'b0, 2'd1, 1'b1, 32'h103, 32'h0, 32'hFFFFCDAB, 1'b0, 3);
    push_beat(32'h100, 1'b0, 4'b1000, 32'h0, 32'hAB000000, 0);
    push_beat(32'h104, 1'b0, 4'b0001, 32'h0, 32'h000000CD, 0);
    issue(1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 32'h0000CDAB, 1'b0, 3);
    drain();

    // Split word store
    push_beat(32'h0FC, 1'b1, 4'b1100, 32'h33440000, 32'hFFFFFFFF, 0);
    push_beat(32'h100, 1'b1, 4'b0011, 32'h00001122, 32'hFFFFFFFF, 0);
    issue(1'b1, 2'd2, 1'b0, 32'h0FE, 32'h11223344, 32'h0, 1'b0, 3);
    drain();

    // Address wrap with three stall cycles per beat
    push_beat(32'hFFFFFFFC, 1'b0, 4'b1100, 32'h0, 32'h55660000, 3);
    push_beat(32'h00000000, 1'b0, 4'b0011, 32'h0, 32'h00007788, 3);
    issue(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 32'h77885566, 1'b0, 9);
    drain();

    // Byte loads: sign and zero extension
    push_beat(32'h100, 1'b0, 4'b0100, 32'h0, 32'h00800000, 0);
    issue(1'b0, 2'd0, 1'b1, 32'h102, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    push_beat(32'h100, 1'b0, 4'b0100, 32'h0, 32'h00800000, 1);
    issue(1'b0, 2'd0, 1'b0, 32'h102, 32'h0, 32'h00000080, 1'b0, 3);
    drain();

    // Illegal size: no bus activity, error response
    issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 2'd3, 1'b1, 32'h104, 32'hCAFEF00D, 32'h0, 1'b1, 1);
    drain();

    // Reset during the second beat of a split load
    push_beat(32'h200, 1'b0, 4'b1000, 32'h0, 32'h11000000, 0);
    push_beat(32'h204, 1'b0, 4'b0111, 32'h0, 32'h00223344, 10);
    issue(1'b0, 2'd2, 1'b0, 32'h203, 32'h0, 32'h0, 1'b0, 0);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      if (u_if.bus_req && u_if.bus_addr == 32'h204) seen = 1'b1;
      else begin
        step();
        k++;
      end
    end
    chk("split_beat1_seen", seen, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_bus_req", u_if.bus_req, 0);
    chk("rst_async_resp_valid", u_if.resp_valid, 0);
    beat_q.delete();
    resp_q.delete();
    bwait = 0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_ready", u_if.req_ready, 1);

    // Byte store after reset
    push_beat(32'h100, 1'b1, 4'b0010, 32'h00005A00, 32'h0, 0);
    issue(1'b1, 2'd0, 1'b0, 32'h101, 32'h1234565A, 32'h0, 1'b0, 2);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
